// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : booth_pkg
// Description : Shared types and helpers for the sequential radix-4 Booth
//               multiplier: digit encodings, FSM states, and the fractional
//               saturation constant.
// Revision    : 1.0 - initial release
// ============================================================================
package booth_pkg;

  // Radix-4 Booth digit. Bit 2 is the sign and bits 1:0 the magnitude.
  typedef enum logic [2:0] {
    ZERO = 3'b000,
    POS1 = 3'b001,
    POS2 = 3'b010,
    NEG1 = 3'b101,
    NEG2 = 3'b110
  } booth_digit_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } booth_state_e;

  // Widest product the saturation helper can describe.
  localparam int unsigned c_max_prod_w = 128;

  // Largest positive Q(2*width-1) value: a zero sign bit followed by ones.
  // Callers slice the low 2*width bits.
  function automatic logic [c_max_prod_w-1:0] frac_sat_const(input int unsigned width);
    logic [c_max_prod_w-1:0] val;
    val = '0;
    for (int unsigned i = 0; i < c_max_prod_w; i++) begin
      if (i < (2 * width) - 1) begin
        val[i] = 1'b1;
      end
    end
    return val;
  endfunction

  // Recode the overlapping triplet {y[2i+1], y[2i], y[2i-1]} to a digit.
  function automatic booth_digit_e booth_recode(input logic [2:0] triplet);
    booth_digit_e digit;
    case (triplet)
      3'b001, 3'b010: digit = POS1;
      3'b011:         digit = POS2;
      3'b100:         digit = NEG2;
      3'b101, 3'b110: digit = NEG1;
      default:        digit = ZERO;
    endcase
    return digit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_multiplier_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : booth_multiplier_seq_if
// Description : Start/done request bus between the execute-stage controller
//               (master) and the sequential Booth multiplier (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface booth_multiplier_seq_if #(
  parameter int WIDTH = 16
) ();

  logic                   start;
  logic                   frac_mode;
  logic [WIDTH-1:0]       real_x;
  logic [WIDTH-1:0]       real_y;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product;
  logic                   saturated;

  modport master (
    output start, frac_mode, real_x, real_y,
    input  busy, done, product, saturated
  );

  modport slave (
    input  start, frac_mode, real_x, real_y,
    output busy, done, product, saturated
  );

endinterface
`default_nettype wire

// File: rtl/booth_r4_encoder.sv
`default_nettype none
// ============================================================================
// Module      : booth_r4_encoder
// Description : Combinational radix-4 Booth partial-product generator. Turns a
//               multiplier triplet and the multiplicand into digit*x,
//               sign-extended to 2*WIDTH+2 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_r4_encoder
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]         triplet,
  input  logic [WIDTH-1:0]   multiplicand,
  output logic [2*WIDTH+1:0] partial
);

  booth_digit_e        digit;
  logic [2*WIDTH+1:0]  x_ext;

  // Select 0, +-x or +-2x according to the recoded digit.
  always_comb begin
    digit   = booth_recode(triplet);
    x_ext   = {{(WIDTH + 2){multiplicand[WIDTH-1]}}, multiplicand};
    partial = '0;
    case (digit)
      POS1:    partial = x_ext;
      POS2:    partial = x_ext << 1;
      NEG1:    partial = '0 - x_ext;
      NEG2:    partial = '0 - (x_ext << 1);
      default: partial = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/booth_multiplier_seq.sv
`default_nettype none
// ============================================================================
// Module      : booth_multiplier_seq
// Description : Sequential radix-4 Booth multiplier, one partial product per
//               clock, signed-integer or Q(WIDTH-1) fractional output with
//               saturation of the -1 x -1 fractional case.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_multiplier_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  booth_multiplier_seq_if.slave  bus
);

  localparam int unsigned c_acc_w  = 2 * WIDTH + 2;
  localparam int unsigned c_prod_w = 2 * WIDTH;
  localparam int unsigned c_cnt_w  = $clog2(WIDTH / 2 + 1);

  localparam logic [c_cnt_w-1:0]      c_steps   = c_cnt_w'(WIDTH / 2);
  localparam logic [WIDTH-1:0]        c_min_val = {1'b1, {(WIDTH - 1){1'b0}}};
  localparam logic [c_max_prod_w-1:0] c_sat_all = frac_sat_const(WIDTH);
  localparam logic [c_prod_w-1:0]     c_sat_val = c_sat_all[c_prod_w-1:0];

  booth_state_e         state_q,     state_d;
  logic [c_cnt_w-1:0]   cnt_q,       cnt_d;
  logic [c_acc_w-1:0]   acc_q,       acc_d;
  logic [WIDTH-1:0]     x_q,         x_d;
  // Working multiplier with the implicit y[-1]=0 appended at bit 0.
  logic [WIDTH:0]       y_q,         y_d;
  logic                 frac_q,      frac_d;
  logic                 sat_case_q,  sat_case_d;
  logic                 busy_q,      busy_d;
  logic                 done_q,      done_d;
  logic [c_prod_w-1:0]  product_q,   product_d;
  logic                 saturated_q, saturated_d;

  logic [c_acc_w-1:0]   pp;
  logic [c_acc_w-1:0]   pp_aligned;
  logic [c_acc_w-1:0]   acc_sum;
  logic [c_cnt_w:0]     shamt;

  booth_r4_encoder #(
    .WIDTH (WIDTH)
  ) u_encoder (
    .triplet      (y_q[2:0]),
    .multiplicand (x_q),
    .partial      (pp)
  );

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    x_d         = x_q;
    y_d         = y_q;
    frac_d      = frac_q;
    sat_case_d  = sat_case_q;
    product_d   = product_q;
    saturated_d = saturated_q;
    done_d      = 1'b0;

    // Digit i carries weight 4^i; i counts up as the counter counts down.
    shamt      = {c_steps - cnt_q, 1'b0};
    pp_aligned = pp << shamt;
    acc_sum    = acc_q + pp_aligned;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_d        = bus.real_x;
          y_d        = {bus.real_y, 1'b0};
          frac_d     = bus.frac_mode;
          sat_case_d = bus.frac_mode && (bus.real_x == c_min_val) && (bus.real_y == c_min_val);
          acc_d      = '0;
          cnt_d      = c_steps;
          state_d    = CALC;
        end
      end

      CALC: begin
        acc_d = acc_sum;
        y_d   = {{2{y_q[WIDTH]}}, y_q[WIDTH:2]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == c_cnt_w'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          if (!frac_q) begin
            product_d   = acc_sum[c_prod_w-1:0];
            saturated_d = 1'b0;
          end else if (sat_case_q) begin
            product_d   = c_sat_val;
            saturated_d = 1'b1;
          end else begin
            product_d   = {acc_sum[c_prod_w-2:0], 1'b0};
            saturated_d = 1'b0;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      frac_q      <= 1'b0;
      sat_case_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      product_q   <= '0;
      saturated_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      x_q         <= x_d;
      y_q         <= y_d;
      frac_q      <= frac_d;
      sat_case_q  <= sat_case_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      product_q   <= product_d;
      saturated_q <= saturated_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.product   = product_q;
  assign bus.saturated = saturated_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_multiplier_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_multiplier_seq
// Description : Directed self-checking bench for booth_multiplier_seq
//               (WIDTH=16) with hand-computed expected products.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_multiplier_seq;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  booth_multiplier_seq_if #(.WIDTH(16)) bus ();

  booth_multiplier_seq #(
    .WIDTH (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One operation from IDLE. glitch_at >= 0 pulses start with other operands
  // in that CALC cycle (0 = first CALC cycle after the accepting edge).
  task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input logic fm, input logic [31:0] exp_p, input logic exp_s,
                        input int glitch_at);
    int  k;
    bit  got;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.real_x    = x;
    bus.real_y    = y;
    bus.frac_mode = fm;
    @(posedge clk);
    #1;
    chk({tag, ".busy_after_accept"}, {31'd0, bus.busy}, 32'd1);
    bus.start     = 1'b0;
    bus.real_x    = 16'($urandom);
    bus.real_y    = 16'($urandom);
    bus.frac_mode = 1'($urandom);
    k   = 0;
    got = 1'b0;
    while (!got && k < 20) begin
      if (k == glitch_at) begin
        @(negedge clk);
        bus.start     = 1'b1;
        bus.real_x    = 16'h7FFF;
        bus.real_y    = 16'h7FFF;
        bus.frac_mode = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      k++;
      if (bus.done === 1'b1) got = 1'b1;
    end
    // done is expected in the 9th cycle after the accepting edge's cycle.
    chk({tag, ".latency"}, got ? k : 0, 32'd8);
    chk({tag, ".product"}, bus.product, exp_p);
    chk({tag, ".saturated"}, {31'd0, bus.saturated}, {31'd0, exp_s});
    @(posedge clk);
    #1;
    chk({tag, ".done_single"}, {31'd0, bus.done}, 32'd0);
    chk({tag, ".busy_idle"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, ".product_hold"}, bus.product, exp_p);
  endtask

  initial begin
    int  n;
    int  m;
    bit  saw_done;
    n_cmp = 0;
    n_err = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.frac_mode = 1'b0;
    bus.real_x    = '0;
    bus.real_y    = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy",      {31'd0, bus.busy},      32'd0);
    chk("reset.done",      {31'd0, bus.done},      32'd0);
    chk("reset.product",   bus.product,            32'd0);
    chk("reset.saturated", {31'd0, bus.saturated}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("int_fcd0_0876",  16'hFCD0, 16'h0876, 1'b0, 32'hFFE507E0, 1'b0, -1);
    run_op("frac_fcd0_0876", 16'hFCD0, 16'h0876, 1'b1, 32'hFFCA0FC0, 1'b0, -1);
    run_op("int_7fff_7fff",  16'h7FFF, 16'h7FFF, 1'b0, 32'h3FFF0001, 1'b0, -1);
    run_op("frac_7fff_7fff", 16'h7FFF, 16'h7FFF, 1'b1, 32'h7FFE0002, 1'b0, -1);
    run_op("int_8000_8000",  16'h8000, 16'h8000, 1'b0, 32'h40000000, 1'b0, -1);
    run_op("frac_8000_8000", 16'h8000, 16'h8000, 1'b1, 32'h7FFFFFFF, 1'b1, -1);
    run_op("int_neg1_pos1",  16'hFFFF, 16'h0001, 1'b0, 32'hFFFFFFFF, 1'b0, -1);

    // start during the 3rd CALC cycle must be ignored entirely.
    run_op("busy_start", 16'hFCD0, 16'h0876, 1'b0, 32'hFFE507E0, 1'b0, 2);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_start.no_queue_busy", {31'd0, bus.busy}, 32'd0);
    chk("busy_start.product_kept",  bus.product, 32'hFFE507E0);

    // start held high: back-to-back operations with one IDLE cycle between.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.real_x    = 16'h7FFF;
    bus.real_y    = 16'h7FFF;
    bus.frac_mode = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bus.done !== 1'b1 && n < 30);
    chk("b2b.first_done_edges", n, 32'd9);
    m = 0;
    do begin
      @(posedge clk);
      #1;
      m++;
    end while (bus.done !== 1'b1 && m < 30);
    chk("b2b.second_done_edges", m, 32'd10);
    chk("b2b.product", bus.product, 32'h3FFF0001);
    bus.start = 1'b0;
    repeat (2) @(posedge clk);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.real_x    = 16'h8000;
    bus.real_y    = 16'h8000;
    bus.frac_mode = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset.busy",      {31'd0, bus.busy},      32'd0);
    chk("midreset.done",      {31'd0, bus.done},      32'd0);
    chk("midreset.product",   bus.product,            32'd0);
    chk("midreset.saturated", {31'd0, bus.saturated}, 32'd0);
    saw_done = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    chk("midreset.no_done", {31'd0, saw_done}, 32'd0);

    run_op("zero_x", 16'h0000, 16'h1234, 1'b0, 32'h00000000, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
